i2s_receiver: RTL and testbench

Receives stereo audio from the ADAU codec ADC serial output (I2S, Philips format) and delivers complete left/right sample pairs to the SoC through a small FIFO with a read handshake. It is the receive-direction counterpart of `i2s_master` and uses the same `frame_*_l/_r` and `full`/`empty` handshake style. It runs entirely in the `clk_soc` domain. `bclk`, `lrclk` and `sdata` are sampled as asynchronous inputs; the block generates no audio clocks.

---
 rtl/i2s_receiver.sv | 186 ++++++++++++++++++
 tb/tb_i2s_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S (Philips) stereo receiver: conditions the asynchronous codec pins in the clk_soc domain,
// assembles left/right sample pairs and queues them in a show-ahead FIFO with a read handshake.
module i2s_receiver #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk_soc,
    input  logic                        rstn_i,
    input  logic                        bclk,
    input  logic                        lrclk,
    input  logic                        sdata,
    output logic [SAMPLE_WIDTH-1:0]     frame_out_l,
    output logic [SAMPLE_WIDTH-1:0]     frame_out_r,
    output logic                        empty,
    input  logic                        read_frame,
    output logic [$clog2(FIFO_DEPTH):0] fill,
    output logic                        overflow,
    input  logic                        ovf_clr
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CntW-1:0] FullCnt  = CntW'(SAMPLE_WIDTH);
    localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StHunt, StRxL, StRxR} state_e;

    // Input conditioning
    logic [1:0] bclk_sync_q, ws_sync_q, sd_sync_q;
    logic       bclk_prev_q, evt_q, evt_ws_q, evt_sd_q;

    always_ff @(posedge clk_soc) begin
        if (!rstn_i) begin
            bclk_sync_q <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            evt_q       <= 1'b0;
            evt_ws_q    <= 1'b0;
            evt_sd_q    <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], bclk};
            ws_sync_q   <= {ws_sync_q[0], lrclk};
            sd_sync_q   <= {sd_sync_q[0], sdata};
            bclk_prev_q <= bclk_sync_q[1];
            // Registered edge pulse carries ws/sdata captured in the same cycle
            evt_q       <= bclk_sync_q[1] & ~bclk_prev_q;
            evt_ws_q    <= ws_sync_q[1];
            evt_sd_q    <= sd_sync_q[1];
        end
    end

    // Framing state machine and shift register
    state_e                  state_q, state_d;
    logic                    primed_q, primed_d;
    logic                    ws_prev_q, ws_prev_d;
    logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
    logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
    logic                    bad_q, bad_d;
    logic                    push_q, push_d;
    logic [SAMPLE_WIDTH-1:0] push_l_q, push_l_d, push_r_q, push_r_d;
    logic                    chan_start, full_word;

    assign chan_start = evt_q & primed_q & (evt_ws_q != ws_prev_q);
    assign full_word  = (bit_cnt_q == FullCnt);

    always_comb begin
        state_d   = state_q;
        primed_d  = primed_q;
        ws_prev_d = ws_prev_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        hold_l_d  = hold_l_q;
        bad_d     = bad_q;
        push_d    = 1'b0;
        push_l_d  = push_l_q;
        push_r_d  = push_r_q;

        if (evt_q) begin
            primed_d  = 1'b1;
            ws_prev_d = evt_ws_q;
            if (chan_start) begin
                bit_cnt_d = '0;
            end else if (bit_cnt_q < FullCnt) begin
                shreg_d   = {shreg_q[SAMPLE_WIDTH-2:0], evt_sd_q};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (chan_start) begin
            unique case (state_q)
                StHunt: begin
                    if (!evt_ws_q) state_d = StRxL;
                end
                StRxL: begin
                    if (evt_ws_q) begin
                        if (full_word) hold_l_d = shreg_q;
                        else           bad_d    = 1'b1;
                        state_d = StRxR;
                    end
                end
                StRxR: begin
                    if (!evt_ws_q) begin
                        if (full_word && !bad_q) begin
                            push_d   = 1'b1;
                            push_l_d = hold_l_q;
                            push_r_d = shreg_q;
                        end
                        bad_d   = 1'b0;
                        state_d = StRxL;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk_soc) begin
        if (!rstn_i) begin
            state_q   <= StHunt;
            primed_q  <= 1'b0;
            ws_prev_q <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            hold_l_q  <= '0;
            bad_q     <= 1'b0;
            push_q    <= 1'b0;
            push_l_q  <= '0;
            push_r_q  <= '0;
        end else begin
            state_q   <= state_d;
            primed_q  <= primed_d;
            ws_prev_q <= ws_prev_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            hold_l_q  <= hold_l_d;
            bad_q     <= bad_d;
            push_q    <= push_d;
            push_l_q  <= push_l_d;
            push_r_q  <= push_r_d;
        end
    end

    // Pair FIFO
    logic [SAMPLE_WIDTH-1:0] mem_l_q [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_r_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]           count_q;
    logic                    full, pop, wr_en, ovf_set;

    assign full    = (count_q == DepthCnt);
    assign pop     = read_frame & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign wr_en   = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    always_ff @(posedge clk_soc) begin
        if (rstn_i && wr_en) begin
            mem_l_q[wr_ptr_q] <= push_l_q;
            mem_r_q[wr_ptr_q] <= push_r_q;
        end
    end

    always_ff @(posedge clk_soc) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop)      count_q <= count_q + 1'b1;
            else if (!wr_en && pop) count_q <= count_q - 1'b1;
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign empty       = (count_q == '0);
    assign fill        = count_q;
    assign frame_out_l = empty ? '0 : mem_l_q[rd_ptr_q];
    assign frame_out_r = empty ? '0 : mem_r_q[rd_ptr_q];

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives I2S frames bit by bit and checks FIFO contents,
// flags and the fixed pin-to-empty latency against hand-computed values.
module tb_i2s_receiver;

    logic        clk_soc = 1'b0;
    logic        rstn_i = 1'b0;
    logic        bclk = 1'b0;
    logic        lrclk = 1'b1;
    logic        sdata = 1'b0;
    logic        read_frame = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [23:0] frame_out_l, frame_out_r;
    logic        empty, overflow;
    logic [2:0]  fill;

    int n_vec = 0;
    int n_err = 0;
    bit left_open = 1'b0;

    i2s_receiver #(.SAMPLE_WIDTH(24), .FIFO_DEPTH(4)) dut (
        .clk_soc    (clk_soc),
        .rstn_i     (rstn_i),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .frame_out_l(frame_out_l),
        .frame_out_r(frame_out_r),
        .empty      (empty),
        .read_frame (read_frame),
        .fill       (fill),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk_soc = ~clk_soc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bit_event(input logic ws, input logic b);
        @(negedge clk_soc);
        lrclk = ws;
        sdata = b;
        bclk  = 1'b0;
        repeat (4) @(negedge clk_soc);
        bclk = 1'b1;
        repeat (4) @(negedge clk_soc);
    endtask

    // Event 0 of a slot is the channel start; bits 1..24 carry the word MSB first
    task automatic send_slot(input logic ws, input logic [23:0] word, input int nev);
        logic [23:0] w;
        w = word;
        for (int i = 0; i < nev; i++) begin
            if (!(i == 0 && !ws && left_open))
                bit_event(ws, (i >= 1 && i <= 24) ? w[24 - i] : 1'b0);
        end
        left_open = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic close_frame();
        bit_event(1'b0, 1'b0);
        left_open = 1'b1;
        repeat (4) @(negedge clk_soc);
    endtask

    task automatic pop_one();
        @(negedge clk_soc);
        read_frame = 1'b1;
        @(negedge clk_soc);
        read_frame = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_soc);
        rstn_i = 1'b0;
        bclk   = 1'b0;
        lrclk  = 1'b1;
        repeat (2) @(negedge clk_soc);
        rstn_i    = 1'b1;
        left_open = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_vec++; if (fill !== 3'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_vec++; if (frame_out_l !== 24'h0) begin n_err++; $display("FAIL reset_l: got %h want 0", frame_out_l); end
        n_vec++; if (frame_out_r !== 24'h0) begin n_err++; $display("FAIL reset_r: got %h want 0", frame_out_r); end
    endtask

    task automatic test_basic_pair();
        do_reset();
        send_slot(1'b1, 24'h0, 2);
        send_frame(24'h123456, 24'hABCDEF);
        // Timed left start: first posedge after the rise is E0, empty must fall after E4
        @(negedge clk_soc);
        lrclk = 1'b0;
        sdata = 1'b0;
        bclk  = 1'b0;
        repeat (4) @(negedge clk_soc);
        bclk = 1'b1;
        repeat (4) @(posedge clk_soc);
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_e3: got %b want 1", empty); end
        @(posedge clk_soc);
        #1;
        n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL basic_empty_e4: got %b want 0", empty); end
        left_open = 1'b1;
        repeat (4) @(negedge clk_soc);
        n_vec++; if (frame_out_l !== 24'h123456) begin n_err++; $display("FAIL basic_l: got %h want 123456", frame_out_l); end
        n_vec++; if (frame_out_r !== 24'hABCDEF) begin n_err++; $display("FAIL basic_r: got %h want abcdef", frame_out_r); end
        n_vec++; if (fill !== 3'd1) begin n_err++; $display("FAIL basic_fill: got %0d want 1", fill); end
        pop_one();
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_pop_empty: got %b want 1", empty); end
        n_vec++; if (fill !== 3'd0) begin n_err++; $display("FAIL basic_pop_fill: got %0d want 0", fill); end
    endtask

    task automatic test_mid_frame();
        @(negedge clk_soc);
        rstn_i = 1'b0;
        send_slot(1'b1, 24'h5A5A5A, 10);
        @(negedge clk_soc);
        rstn_i    = 1'b1;
        left_open = 1'b0;
        send_slot(1'b1, 24'h3C3C3C, 22);
        send_frame(24'h000001, 24'h000002);
        send_frame(24'h000003, 24'h000004);
        close_frame();
        n_vec++; if (fill !== 3'd2) begin n_err++; $display("FAIL mid_fill: got %0d want 2", fill); end
        n_vec++; if (frame_out_l !== 24'h000001) begin n_err++; $display("FAIL mid_l1: got %h want 000001", frame_out_l); end
        n_vec++; if (frame_out_r !== 24'h000002) begin n_err++; $display("FAIL mid_r1: got %h want 000002", frame_out_r); end
        pop_one();
        n_vec++; if (frame_out_l !== 24'h000003) begin n_err++; $display("FAIL mid_l2: got %h want 000003", frame_out_l); end
        n_vec++; if (frame_out_r !== 24'h000004) begin n_err++; $display("FAIL mid_r2: got %h want 000004", frame_out_r); end
        pop_one();
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        logic [23:0] el, er;
        do_reset();
        send_slot(1'b1, 24'h0, 2);
        for (int k = 1; k <= 5; k++) send_frame(24'h100000 + 24'(k), 24'h200000 + 24'(k));
        close_frame();
        n_vec++; if (fill !== 3'd4) begin n_err++; $display("FAIL ovf_fill: got %0d want 4", fill); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
        for (int k = 1; k <= 4; k++) begin
            el = 24'h100000 + 24'(k);
            er = 24'h200000 + 24'(k);
            n_vec++; if (frame_out_l !== el) begin n_err++; $display("FAIL ovf_l%0d: got %h want %h", k, frame_out_l, el); end
            n_vec++; if (frame_out_r !== er) begin n_err++; $display("FAIL ovf_r%0d: got %h want %h", k, frame_out_r, er); end
            pop_one();
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained: got %b want 1", empty); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        @(negedge clk_soc);
        ovf_clr = 1'b1;
        @(negedge clk_soc);
        ovf_clr = 1'b0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    endtask

    task automatic test_push_pop();
        logic [23:0] el, er;
        do_reset();
        send_slot(1'b1, 24'h0, 2);
        for (int k = 1; k <= 5; k++) send_frame(24'h300000 + 24'(k), 24'h400000 + 24'(k));
        n_vec++; if (fill !== 3'd4) begin n_err++; $display("FAIL pp_full: got %0d want 4", fill); end
        // Left start of frame 6 pushes frame 5 at E4; pop in that very cycle
        @(negedge clk_soc);
        lrclk = 1'b0;
        sdata = 1'b0;
        bclk  = 1'b0;
        repeat (4) @(negedge clk_soc);
        bclk = 1'b1;
        repeat (4) @(posedge clk_soc);
        #1 read_frame = 1'b1;
        @(posedge clk_soc);
        #1 read_frame = 1'b0;
        left_open = 1'b1;
        repeat (4) @(negedge clk_soc);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf: got %b want 0", overflow); end
        n_vec++; if (fill !== 3'd4) begin n_err++; $display("FAIL pp_fill: got %0d want 4", fill); end
        for (int k = 2; k <= 5; k++) begin
            el = 24'h300000 + 24'(k);
            er = 24'h400000 + 24'(k);
            n_vec++; if (frame_out_l !== el) begin n_err++; $display("FAIL pp_l%0d: got %h want %h", k, frame_out_l, el); end
            n_vec++; if (frame_out_r !== er) begin n_err++; $display("FAIL pp_r%0d: got %h want %h", k, frame_out_r, er); end
            pop_one();
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL pp_empty: got %b want 1", empty); end
    endtask

    task automatic test_truncated();
        do_reset();
        send_slot(1'b1, 24'h0, 2);
        send_slot(1'b0, 24'h0F0F0F, 11);
        send_slot(1'b1, 24'h777777, 32);
        send_frame(24'h0A0A0A, 24'h0B0B0B);
        close_frame();
        n_vec++; if (fill !== 3'd1) begin n_err++; $display("FAIL trunc_fill: got %0d want 1", fill); end
        n_vec++; if (frame_out_l !== 24'h0A0A0A) begin n_err++; $display("FAIL trunc_l: got %h want 0a0a0a", frame_out_l); end
        n_vec++; if (frame_out_r !== 24'h0B0B0B) begin n_err++; $display("FAIL trunc_r: got %h want 0b0b0b", frame_out_r); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_slot(1'b1, 24'h0, 2);
        send_frame(24'h111111, 24'h222222);
        send_frame(24'h333333, 24'h444444);
        send_slot(1'b0, 24'h555555, 32);
        send_slot(1'b1, 24'h666666, 12);
        n_vec++; if (fill !== 3'd2) begin n_err++; $display("FAIL rmid_pre_fill: got %0d want 2", fill); end
        @(negedge clk_soc);
        rstn_i = 1'b0;
        @(negedge clk_soc);
        rstn_i = 1'b1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b want 1", empty); end
        n_vec++; if (fill !== 3'd0) begin n_err++; $display("FAIL rmid_fill: got %0d want 0", fill); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rmid_ovf: got %b want 0", overflow); end
        n_vec++; if (frame_out_l !== 24'h0) begin n_err++; $display("FAIL rmid_l: got %h want 0", frame_out_l); end
        n_vec++; if (frame_out_r !== 24'h0) begin n_err++; $display("FAIL rmid_r: got %h want 0", frame_out_r); end
        send_slot(1'b1, 24'h666666, 20);
        send_frame(24'h0C0C0C, 24'h0D0D0D);
        close_frame();
        n_vec++; if (fill !== 3'd1) begin n_err++; $display("FAIL rmid_next_fill: got %0d want 1", fill); end
        n_vec++; if (frame_out_l !== 24'h0C0C0C) begin n_err++; $display("FAIL rmid_next_l: got %h want 0c0c0c", frame_out_l); end
        n_vec++; if (frame_out_r !== 24'h0D0D0D) begin n_err++; $display("FAIL rmid_next_r: got %h want 0d0d0d", frame_out_r); end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_mid_frame();
        test_overflow();
        test_push_pop();
        test_truncated();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
